mov_exec_unit: RTL and testbench
================================

// Module: mov_exec_unit
// PURPOSE
// Parametrised MOV/NOT/LUI execution unit for the stamp-based scheduler window.
// - Each cycle it issues the oldest ready MOV/NOT slot: reads the source register
//   and parks the result in a tracked result buffer.
// - Each cycle it retires the oldest ready MOV/NOT/LUI slot to the register file.
// - Result-buffer occupancy is tracked and the unit stalls when the buffer is full.
// - Stamp, take and register-write outputs are registered, so each slot is masked
//   for one cycle after issue to prevent double issue.
// PARAMETERS
// SLOTS     8   scheduler window slots; highest index = oldest
// DATA_W    32  register data width
// INST_W    88  slot record width
// BUF_DEPTH 32  result buffer entries; power of 2, >= 2
// TAG_W     5   log2(BUF_DEPTH); also the width of the record tag field
// EN_NOT    1   1 = NOT supported; 0 = NOT opcode ignored in both phases
// PORTS
// clk             in   1              clock, rising edge
// reset           in   1              asynchronous reset, active-high
// reg_start_flat  in   SLOTS*3        per-slot start code; 100 = execute ready, 001 = writeback ready
// reg_out_flat    in   SLOTS*INST_W   per-slot instruction record
// stamp_flat      out  SLOTS*3        per-slot stamp value; valid only where stamp_in bit = 1
// stamp_in        out  SLOTS          one-cycle stamp strobe per slot
// take_flat       out  SLOTS*TAG_W    per-slot allocated buffer tag
// take_in         out  SLOTS          one-cycle take strobe per slot
// reg_search_out2 out  5              register read address (combinational)
// reg_out2        in   DATA_W         register read data, same cycle
// reg_search_in2  out  5              register write address
// reg_in2         out  DATA_W         register write data
// reg_in2_start   out  1              one-cycle register write strobe
// buf_count       out  TAG_W+1        valid buffer entries
// buf_full        out  1              buf_count == BUF_DEPTH
// tag_err         out  1              sticky: writeback hit an invalid tag
// BEHAVIOUR
// - Record fields: op[87:82], rs[81:77], rd[71:67], imm[66:35] (DATA_W), tag[34:30], stamp[2:0].
// - Opcodes: MOV = 101010, NOT = 101100, LUI = 001001.
// - Reset (async) clears all registered outputs to 0, buffer valid bits, the issue mask and tag_err.
//   - Buffer data is not cleared.
//   - Reset mid-operation discards in-flight results; no strobe fires on the release cycle.
// - EXECUTE phase (cycle N, combinational select):
//   - Candidate: start = 100, op MOV or NOT, not masked.
//   - Pick the highest-index candidate.
//   - reg_search_out2 = rs of the picked slot; it is 0 when there is no candidate.
//   - Issue only if buf_full = 0.
// - EXECUTE phase, on issue at posedge N+1:
//   - alloc = lowest invalid buffer index, from valid bits before this cycle's free.
//   - buf[alloc] <= reg_out2 (MOV) or ~reg_out2 (NOT); the entry is set valid.
//   - take[i] <= alloc; take_in[i] <= 1.
//   - stamp[i] <= {1, rec[1:0]}; stamp_in[i] <= 1.
//   - mask[i] <= 1 for exactly one cycle.
// - WRITEBACK phase (cycle N, independent of execute):
//   - Candidate: start = 001, op MOV, NOT or LUI; pick the highest-index candidate.
//   - At posedge N+1: reg_search_in2 <= rd; reg_in2_start <= 1.
//   - reg_in2 <= imm for LUI, else buf[tag].
//   - stamp[i] <= {rec[2:1], 1}; stamp_in[i] <= 1.
//   - For MOV/NOT the entry buf[tag] is freed (valid <= 0).
// - Writeback with tag invalid (MOV/NOT):
//   - No register write and no stamp; the slot stays pending.
//   - tag_err <= 1.
// - Strobes (stamp_in, take_in, reg_in2_start) are high for one cycle only.
//   - Unselected slots read stamp_flat/take_flat as 0.
//   - Execute and writeback may strobe different slots in the same cycle.
// - Alloc and free in the same cycle:
//   - The freed entry is not reusable until the next cycle.
//   - buf_count changes by +1, -1 or 0 (net).
// - Full: no issue and no strobes. Execute candidates wait and writeback proceeds, so the
//   cycle after a free, issue resumes.
// - Opcodes not listed, or NOT when EN_NOT = 0, are never selected.
// TESTING
// 1. MOV, slot 3, rs=5, reg_out2=0x1234_5678
//    -> next cycle take_in=0x08, take[3]=0, stamp[3]=100, buf_count=1.
//    -> writeback with rd=9 -> reg_in2=0x12345678, reg_in2_start=1, buf_count=0.
// 2. NOT on 0x0000_FFFF -> writeback 0xFFFF_0000.
//    -> LUI imm=0xABCD_0000 -> reg_in2=0xABCD0000, no buffer change.
// 3. Slots 2 and 6 both execute-ready -> slot 6 issues first.
//    -> slot 6 is masked the next cycle, so slot 2 issues then; the two tags differ.
// 4. Fill 32 entries -> buf_full=1 and a further issue is blocked with no strobes.
//    -> one writeback frees an entry -> the next cycle's issue allocates that freed tag.
// 5. Writeback with an unallocated tag -> tag_err=1 and reg_in2_start stays 0.
// 6. Assert reset mid-stream, between an issue and its writeback
//    -> all outputs 0 and buf_count=0 immediately (async).

Source files
------------

// File: rtl/mov_exec_unit.sv
// mov_exec_unit
// MOV/NOT/LUI execution unit for the stamp-based scheduler window.
// Each cycle the oldest execute-ready MOV/NOT slot reads its source register
// and parks the result in a tracked result buffer. Independently, the oldest
// writeback-ready MOV/NOT/LUI slot retires to the register file.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   reg_start_flat   per-slot start code (100 execute ready, 001 writeback ready)
//   reg_out_flat     per-slot instruction record
//   stamp_flat/_in   per-slot stamp value and one-cycle strobe
//   take_flat/_in    per-slot allocated buffer tag and one-cycle strobe
//   reg_search_out2  register read address (combinational), reg_out2 read data
//   reg_search_in2   register write address, reg_in2 write data, reg_in2_start strobe
//   buf_count        valid buffer entries, buf_full when all entries are valid
//   tag_err          sticky flag: writeback referenced an invalid buffer tag
module mov_exec_unit #(
    parameter int SLOTS     = 8,
    parameter int DATA_W    = 32,
    parameter int INST_W    = 88,
    parameter int BUF_DEPTH = 32,
    parameter int TAG_W     = 5,
    parameter int EN_NOT    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SLOTS*3-1:0]        reg_start_flat,
    input  logic [SLOTS*INST_W-1:0]   reg_out_flat,
    output logic [SLOTS*3-1:0]        stamp_flat,
    output logic [SLOTS-1:0]          stamp_in,
    output logic [SLOTS*TAG_W-1:0]    take_flat,
    output logic [SLOTS-1:0]          take_in,
    output logic [4:0]                reg_search_out2,
    input  logic [DATA_W-1:0]         reg_out2,
    output logic [4:0]                reg_search_in2,
    output logic [DATA_W-1:0]         reg_in2,
    output logic                      reg_in2_start,
    output logic [TAG_W:0]            buf_count,
    output logic                      buf_full,
    output logic                      tag_err
);

    localparam int SIDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int OP_LSB  = 82;
    localparam int RS_LSB  = 77;
    localparam int RD_LSB  = 67;
    localparam int IMM_LSB = 35;
    localparam int TAG_LSB = 30;
    localparam logic [5:0] OP_MOV = 6'b101010;
    localparam logic [5:0] OP_NOT = 6'b101100;
    localparam logic [5:0] OP_LUI = 6'b001001;

    logic [DATA_W-1:0]    buf_mem_r [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_valid_r;
    logic [SLOTS-1:0]     mask_r;

    logic [SLOTS-1:0]     ex_cand_s, wb_cand_s;
    logic                 ex_hit_s, wb_hit_s, ex_issue_s;
    logic [SIDX_W-1:0]    ex_idx_s, wb_idx_s;
    int                   ex_base_s, wb_base_s;
    logic [5:0]           ex_op_s, wb_op_s;
    logic [2:0]           ex_st_s, wb_st_s;
    logic [4:0]           wb_rd_s;
    logic [TAG_W-1:0]     wb_tag_s, alloc_s;
    logic                 wb_is_lui_s, wb_fire_s, wb_free_s, wb_err_s;
    logic [DATA_W-1:0]    ex_data_s, wb_wdata_s;
    logic [BUF_DEPTH-1:0] valid_nxt_s;
    logic [TAG_W:0]       count_nxt_s;
    logic                 unused_rec_s;

    // MOV always executes here; NOT only when the variant supports it.
    function automatic logic is_exec_op(input logic [5:0] op);
        return (op == OP_MOV) || ((EN_NOT != 0) && (op == OP_NOT));
    endfunction

    // Highest set bit wins: highest slot index is the oldest instruction.
    function automatic logic [SIDX_W-1:0] pick_highest(input logic [SLOTS-1:0] v);
        logic [SIDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < SLOTS; i++) begin
            idx = v[i] ? SIDX_W'(i) : idx;
        end
        return idx;
    endfunction

    // Record bits outside the decoded fields are deliberately ignored.
    assign unused_rec_s = ^reg_out_flat;

    // Candidate vectors for both phases.
    always_comb begin
        ex_cand_s = '0;
        wb_cand_s = '0;
        for (int i = 0; i < SLOTS; i++) begin
            ex_cand_s[i] = (reg_start_flat[i*3 +: 3] == 3'b100)
                         && is_exec_op(reg_out_flat[i*INST_W + OP_LSB +: 6])
                         && !mask_r[i];
            wb_cand_s[i] = (reg_start_flat[i*3 +: 3] == 3'b001)
                         && (is_exec_op(reg_out_flat[i*INST_W + OP_LSB +: 6])
                             || (reg_out_flat[i*INST_W + OP_LSB +: 6] == OP_LUI));
        end
    end

    // Execute select, source read address and result computation.
    always_comb begin
        ex_hit_s        = |ex_cand_s;
        ex_idx_s        = pick_highest(ex_cand_s);
        ex_base_s       = int'(ex_idx_s) * INST_W;
        ex_op_s         = reg_out_flat[ex_base_s + OP_LSB +: 6];
        ex_st_s         = reg_out_flat[ex_base_s +: 3];
        ex_issue_s      = ex_hit_s && !buf_full;
        reg_search_out2 = ex_hit_s ? reg_out_flat[ex_base_s + RS_LSB +: 5] : 5'd0;
        ex_data_s       = (ex_op_s == OP_NOT) ? ~reg_out2 : reg_out2;
    end

    // Lowest free entry, taken from the valid bits before this cycle's free,
    // so an entry released this cycle only becomes allocatable next cycle.
    always_comb begin
        alloc_s = '0;
        for (int i = BUF_DEPTH - 1; i >= 0; i--) begin
            alloc_s = buf_valid_r[i] ? alloc_s : TAG_W'(i);
        end
    end

    // Writeback select; MOV/NOT with an invalid tag stall and flag an error.
    always_comb begin
        wb_hit_s    = |wb_cand_s;
        wb_idx_s    = pick_highest(wb_cand_s);
        wb_base_s   = int'(wb_idx_s) * INST_W;
        wb_op_s     = reg_out_flat[wb_base_s + OP_LSB +: 6];
        wb_st_s     = reg_out_flat[wb_base_s +: 3];
        wb_rd_s     = reg_out_flat[wb_base_s + RD_LSB +: 5];
        wb_tag_s    = reg_out_flat[wb_base_s + TAG_LSB +: TAG_W];
        wb_is_lui_s = (wb_op_s == OP_LUI);
        wb_fire_s   = wb_hit_s && (wb_is_lui_s || buf_valid_r[wb_tag_s]);
        wb_free_s   = wb_fire_s && !wb_is_lui_s;
        wb_err_s    = wb_hit_s && !wb_fire_s;
        wb_wdata_s  = wb_is_lui_s ? reg_out_flat[wb_base_s + IMM_LSB +: DATA_W]
                                  : buf_mem_r[wb_tag_s];
    end

    // Next buffer occupancy: alloc and free always touch different entries.
    always_comb begin
        valid_nxt_s = (buf_valid_r
                       & ~(wb_free_s ? (BUF_DEPTH'(1) << wb_tag_s) : BUF_DEPTH'(0)))
                      | (ex_issue_s ? (BUF_DEPTH'(1) << alloc_s) : BUF_DEPTH'(0));
        count_nxt_s = buf_count + {{TAG_W{1'b0}}, ex_issue_s}
                                - {{TAG_W{1'b0}}, wb_free_s};
    end

    // Result buffer storage; contents are don't-care until the entry is valid.
    always_ff @(posedge clk) begin
        if (ex_issue_s) begin
            buf_mem_r[alloc_s] <= ex_data_s;
        end
    end

    // Registered strobes, tags, stamps, register write port and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stamp_flat     <= '0;
            stamp_in       <= '0;
            take_flat      <= '0;
            take_in        <= '0;
            mask_r         <= '0;
            reg_search_in2 <= 5'd0;
            reg_in2        <= '0;
            reg_in2_start  <= 1'b0;
            buf_valid_r    <= '0;
            buf_count      <= '0;
            buf_full       <= 1'b0;
            tag_err        <= 1'b0;
        end else begin
            stamp_flat <= '0;
            stamp_in   <= '0;
            take_flat  <= '0;
            take_in    <= '0;
            mask_r     <= '0;
            if (ex_issue_s) begin
                stamp_flat[int'(ex_idx_s)*3 +: 3]         <= {1'b1, ex_st_s[1:0]};
                stamp_in[ex_idx_s]                        <= 1'b1;
                take_flat[int'(ex_idx_s)*TAG_W +: TAG_W]  <= alloc_s;
                take_in[ex_idx_s]                         <= 1'b1;
                // Start code is still 100 next cycle; block a second issue.
                mask_r[ex_idx_s]                          <= 1'b1;
            end
            if (wb_fire_s) begin
                stamp_flat[int'(wb_idx_s)*3 +: 3] <= {wb_st_s[2:1], 1'b1};
                stamp_in[wb_idx_s]                <= 1'b1;
            end
            reg_in2_start  <= wb_fire_s;
            reg_search_in2 <= wb_fire_s ? wb_rd_s : 5'd0;
            reg_in2        <= wb_fire_s ? wb_wdata_s : '0;
            buf_valid_r    <= valid_nxt_s;
            buf_count      <= count_nxt_s;
            buf_full       <= (count_nxt_s == (TAG_W+1)'(BUF_DEPTH));
            tag_err        <= tag_err | wb_err_s;
        end
    end

endmodule

// File: tb/tb_mov_exec_unit.sv
module tb_mov_exec_unit;

    localparam int SLOTS = 8;
    localparam int DW    = 32;
    localparam int IW    = 88;
    localparam int DEPTH = 32;
    localparam int TW    = 5;
    localparam logic [5:0] MOV = 6'b101010;
    localparam logic [5:0] NOT = 6'b101100;
    localparam logic [5:0] LUI = 6'b001001;

    logic                  clk;
    logic                  reset;
    logic [SLOTS*3-1:0]    reg_start_flat;
    logic [SLOTS*IW-1:0]   reg_out_flat;
    logic [SLOTS*3-1:0]    stamp_flat;
    logic [SLOTS-1:0]      stamp_in;
    logic [SLOTS*TW-1:0]   take_flat;
    logic [SLOTS-1:0]      take_in;
    logic [4:0]            reg_search_out2;
    logic [DW-1:0]         reg_out2;
    logic [4:0]            reg_search_in2;
    logic [DW-1:0]         reg_in2;
    logic                  reg_in2_start;
    logic [TW:0]           buf_count;
    logic                  buf_full;
    logic                  tag_err;

    mov_exec_unit dut (
        .clk(clk), .reset(reset),
        .reg_start_flat(reg_start_flat), .reg_out_flat(reg_out_flat),
        .stamp_flat(stamp_flat), .stamp_in(stamp_in),
        .take_flat(take_flat), .take_in(take_in),
        .reg_search_out2(reg_search_out2), .reg_out2(reg_out2),
        .reg_search_in2(reg_search_in2), .reg_in2(reg_in2),
        .reg_in2_start(reg_in2_start),
        .buf_count(buf_count), .buf_full(buf_full), .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file seen by the unit's read port.
    logic [DW-1:0] regfile [32];
    assign reg_out2 = regfile[reg_search_out2];

    // Per-slot stimulus.
    logic [2:0]    tb_start [SLOTS];
    logic [IW-1:0] tb_rec   [SLOTS];
    always_comb begin
        reg_start_flat = '0;
        reg_out_flat   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            reg_start_flat[i*3 +: 3]   = tb_start[i];
            reg_out_flat[i*IW +: IW]   = tb_rec[i];
        end
    end

    // Reference model state: buffer as an array of (valid, value) pairs.
    bit            m_valid [DEPTH];
    logic [DW-1:0] m_data  [DEPTH];
    int            m_last_issued;
    bit            m_err;
    int            last_alloc;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_rec(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rd, input logic [31:0] imm,
                                             input logic [4:0] tag, input logic [2:0] st);
        logic [IW-1:0] r;
        r = '0;
        r[87:82] = op;
        r[81:77] = rs;
        r[71:67] = rd;
        r[66:35] = imm;
        r[34:30] = tag;
        r[2:0]   = st;
        return r;
    endfunction

    function automatic int m_count();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_valid[i];
        return n;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < SLOTS; i++) begin
            tb_start[i] = 3'b000;
            tb_rec[i]   = '0;
        end
    endtask

    task automatic set_slot(input int s, input logic [2:0] st, input logic [5:0] op,
                            input logic [4:0] rs, input logic [4:0] rd, input logic [31:0] imm,
                            input logic [4:0] tag, input logic [2:0] stamp);
        tb_start[s] = st;
        tb_rec[s]   = mk_rec(op, rs, rd, imm, tag, stamp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_last_issued = -1;
        m_err = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_stamp_flat"}, 64'(stamp_flat), 64'd0);
        chk({pfx, "_stamp_in"}, 64'(stamp_in), 64'd0);
        chk({pfx, "_take_flat"}, 64'(take_flat), 64'd0);
        chk({pfx, "_take_in"}, 64'(take_in), 64'd0);
        chk({pfx, "_wr_start"}, 64'(reg_in2_start), 64'd0);
        chk({pfx, "_wr_addr"}, 64'(reg_search_in2), 64'd0);
        chk({pfx, "_wr_data"}, 64'(reg_in2), 64'd0);
        chk({pfx, "_count"}, 64'(buf_count), 64'd0);
        chk({pfx, "_full"}, 64'(buf_full), 64'd0);
        chk({pfx, "_tag_err"}, 64'(tag_err), 64'd0);
    endtask

    // One clock: predict from the current inputs, clock, compare, advance model.
    task automatic cycle();
        int e, w, alloc, free_tag;
        logic [5:0] op;
        logic [IW-1:0] r;
        logic [SLOTS*3-1:0]  e_stamp_flat;
        logic [SLOTS-1:0]    e_stamp_in, e_take_in;
        logic [SLOTS*TW-1:0] e_take_flat;
        logic                e_wstart;
        logic [4:0]          e_waddr;
        logic [DW-1:0]       e_wdata, src;
        e = -1; w = -1; alloc = -1; free_tag = -1;
        e_stamp_flat = '0; e_stamp_in = '0; e_take_flat = '0; e_take_in = '0;
        e_wstart = 1'b0; e_waddr = 5'd0; e_wdata = '0;
        #1;
        for (int i = 0; i < SLOTS; i++) begin
            op = tb_rec[i][87:82];
            if (tb_start[i] == 3'b100 && (op == MOV || op == NOT) && i != m_last_issued) e = i;
            if (tb_start[i] == 3'b001 && (op == MOV || op == NOT || op == LUI)) w = i;
        end
        chk("rd_addr", 64'(reg_search_out2), (e >= 0) ? 64'(tb_rec[e][81:77]) : 64'd0);
        if (w >= 0) begin
            r = tb_rec[w];
            if (r[87:82] == LUI || m_valid[r[34:30]]) begin
                e_wstart = 1'b1;
                e_waddr  = r[71:67];
                e_wdata  = (r[87:82] == LUI) ? r[66:35] : m_data[r[34:30]];
                e_stamp_flat[w*3 +: 3] = {r[2:1], 1'b1};
                e_stamp_in[w] = 1'b1;
                if (r[87:82] != LUI) free_tag = int'(r[34:30]);
            end else begin
                m_err = 1'b1;
            end
        end
        if (e >= 0 && m_count() < DEPTH) begin
            for (int k = DEPTH - 1; k >= 0; k--) if (!m_valid[k]) alloc = k;
            r   = tb_rec[e];
            src = regfile[r[81:77]];
            e_stamp_flat[e*3 +: 3] = {1'b1, r[1:0]};
            e_stamp_in[e] = 1'b1;
            e_take_flat[e*TW +: TW] = TW'(alloc);
            e_take_in[e] = 1'b1;
        end
        if (free_tag >= 0) m_valid[free_tag] = 1'b0;
        if (alloc >= 0) begin
            m_valid[alloc] = 1'b1;
            m_data[alloc]  = (tb_rec[e][87:82] == NOT) ? ~src : src;
            m_last_issued  = e;
            last_alloc     = alloc;
        end else begin
            m_last_issued = -1;
        end
        @(posedge clk);
        #1;
        chk("stamp_in", 64'(stamp_in), 64'(e_stamp_in));
        chk("stamp_flat", 64'(stamp_flat), 64'(e_stamp_flat));
        chk("take_in", 64'(take_in), 64'(e_take_in));
        chk("take_flat", 64'(take_flat), 64'(e_take_flat));
        chk("wr_start", 64'(reg_in2_start), 64'(e_wstart));
        if (e_wstart) begin
            chk("wr_addr", 64'(reg_search_in2), 64'(e_waddr));
            chk("wr_data", 64'(reg_in2), 64'(e_wdata));
        end
        chk("buf_count", 64'(buf_count), 64'(m_count()));
        chk("buf_full", 64'(buf_full), 64'(m_count() == DEPTH));
        chk("tag_err", 64'(tag_err), 64'(m_err));
    endtask

    initial begin
        int prev, s, t, t2, t6, nvalid;
        int vlist [$];
        logic [2:0] st;
        logic [5:0] op;
        logic [4:0] tag;

        for (int i = 0; i < 32; i++) regfile[i] = $urandom;
        regfile[5] = 32'h1234_5678;
        regfile[7] = 32'h0000_FFFF;
        last_alloc = 0;
        clear_all();
        model_reset();
        reset = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // MOV issue and writeback through slot 3.
        set_slot(3, 3'b100, MOV, 5'd5, 5'd0, 32'd0, 5'd0, 3'b000);
        cycle();
        chk("t1_take_in", 64'(take_in), 64'h08);
        chk("t1_take3", 64'(take_flat[15 +: 5]), 64'd0);
        chk("t1_stamp3", 64'(stamp_flat[9 +: 3]), 64'b100);
        chk("t1_count", 64'(buf_count), 64'd1);
        clear_all();
        set_slot(3, 3'b001, MOV, 5'd0, 5'd9, 32'd0, 5'd0, 3'b100);
        cycle();
        chk("t1_wdata", 64'(reg_in2), 64'h1234_5678);
        chk("t1_waddr", 64'(reg_search_in2), 64'd9);
        chk("t1_count0", 64'(buf_count), 64'd0);

        // NOT then LUI.
        clear_all();
        set_slot(1, 3'b100, NOT, 5'd7, 5'd0, 32'd0, 5'd0, 3'b011);
        cycle();
        clear_all();
        set_slot(1, 3'b001, NOT, 5'd0, 5'd4, 32'd0, TW'(last_alloc), 3'b110);
        cycle();
        chk("t2_not", 64'(reg_in2), 64'hFFFF_0000);
        clear_all();
        set_slot(4, 3'b001, LUI, 5'd0, 5'd3, 32'hABCD_0000, 5'd0, 3'b000);
        cycle();
        chk("t2_lui", 64'(reg_in2), 64'hABCD_0000);
        chk("t2_lui_count", 64'(buf_count), 64'd0);

        // Writeback against an unallocated tag.
        clear_all();
        set_slot(0, 3'b001, MOV, 5'd0, 5'd2, 32'd0, 5'd17, 3'b000);
        cycle();
        chk("t5_tag_err", 64'(tag_err), 64'd1);
        chk("t5_no_write", 64'(reg_in2_start), 64'd0);

        // Two execute candidates: oldest first, then the other after the mask.
        clear_all();
        set_slot(2, 3'b100, MOV, 5'($urandom_range(0, 31)), 5'd0, 32'd0, 5'd0, 3'($urandom));
        set_slot(6, 3'b100, NOT, 5'($urandom_range(0, 31)), 5'd0, 32'd0, 5'd0, 3'($urandom));
        cycle();
        chk("t3_first", 64'(take_in), 64'h40);
        t6 = int'(take_flat[30 +: 5]);
        cycle();
        chk("t3_second", 64'(take_in), 64'h04);
        t2 = int'(take_flat[10 +: 5]);
        chk("t3_tags_differ", 64'(t2 != t6), 64'd1);

        // Fill the buffer.
        prev = -1;
        for (int n = 0; n < 100 && m_count() < DEPTH; n++) begin
            clear_all();
            do s = int'($urandom_range(0, SLOTS - 1)); while (s == prev);
            prev = s;
            set_slot(s, 3'b100, ($urandom_range(0, 1) != 0) ? MOV : NOT,
                     5'($urandom_range(0, 31)), 5'd0, 32'd0, 5'd0, 3'($urandom));
            cycle();
        end
        chk("t4_full", 64'(buf_full), 64'd1);
        clear_all();
        set_slot(5, 3'b100, MOV, 5'd1, 5'd0, 32'd0, 5'd0, 3'b000);
        cycle();
        chk("t4_blocked", 64'({stamp_in, take_in}), 64'd0);
        t = int'($urandom_range(0, DEPTH - 1));
        set_slot(0, 3'b001, MOV, 5'd0, 5'd11, 32'd0, TW'(t), 3'b000);
        cycle();
        tb_start[0] = 3'b000;
        cycle();
        chk("t4_reuse", 64'(take_flat[25 +: 5]), 64'(t));

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            vlist.delete();
            for (int k = 0; k < DEPTH; k++) if (m_valid[k]) vlist.push_back(k);
            nvalid = vlist.size();
            for (int i = 0; i < SLOTS; i++) begin
                case ($urandom_range(0, 3))
                    0: st = 3'b000;
                    1: st = 3'b100;
                    2: st = 3'b001;
                    default: st = 3'b011;
                endcase
                case ($urandom_range(0, 3))
                    0: op = MOV;
                    1: op = NOT;
                    2: op = LUI;
                    default: op = 6'($urandom);
                endcase
                if (nvalid > 0 && $urandom_range(0, 3) != 0)
                    tag = TW'(vlist[$urandom_range(0, nvalid - 1)]);
                else
                    tag = TW'($urandom);
                set_slot(i, st, op, 5'($urandom), 5'($urandom), $urandom, tag, 3'($urandom));
            end
            cycle();
        end

        // Asynchronous reset between an issue and its writeback.
        clear_all();
        cycle();
        set_slot(6, 3'b100, MOV, 5'd5, 5'd0, 32'd0, 5'd0, 3'b000);
        cycle();
        clear_all();
        set_slot(6, 3'b001, MOV, 5'd0, 5'd8, 32'd0, TW'(last_alloc), 3'b100);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("t6_async");
        clear_all();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle();
        set_slot(2, 3'b100, MOV, 5'd5, 5'd0, 32'd0, 5'd0, 3'b000);
        cycle();
        chk("t6_realloc", 64'(take_flat[10 +: 5]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
